// File: rtl/game_session_if.sv
// game_session_if
//   Bundles the menu handshake, the player's move strobe and the flood-engine
//   link that connect to game_session. Signal names match the surrounding
//   Flood-It design so the wiring at the top level reads one-to-one.
//
//   master : the environment (menu, player input, flood engine)
//   slave  : game_session itself
//
//   Menu    : BEGIN_GAME, final_SIZE, final_COLOR_NUM  -> ACK_BEGIN_GAME
//   Player  : MOVE_VALID, MOVE_COLOR, CORNER_COLOR
//   Engine  : FLOOD_DONE, BOARD_FLOODED               -> FLOOD_START, FLOOD_COLOR
//   Status  : GAME_SIZE, GAME_COLOR_NUM, TOTAL_TRIES, TRIES, IN_GAME, WON, LOST
interface game_session_if;
  logic       BEGIN_GAME;
  logic [4:0] final_SIZE;
  logic [3:0] final_COLOR_NUM;
  logic       ACK_BEGIN_GAME;
  logic       MOVE_VALID;
  logic [2:0] MOVE_COLOR;
  logic [2:0] CORNER_COLOR;
  logic       FLOOD_DONE;
  logic       BOARD_FLOODED;
  logic       FLOOD_START;
  logic [2:0] FLOOD_COLOR;
  logic [4:0] GAME_SIZE;
  logic [3:0] GAME_COLOR_NUM;
  logic [7:0] TOTAL_TRIES;
  logic [7:0] TRIES;
  logic       IN_GAME;
  logic       WON;
  logic       LOST;

  modport master (
    output BEGIN_GAME, final_SIZE, final_COLOR_NUM,
    output MOVE_VALID, MOVE_COLOR, CORNER_COLOR,
    output FLOOD_DONE, BOARD_FLOODED,
    input  ACK_BEGIN_GAME, FLOOD_START, FLOOD_COLOR,
    input  GAME_SIZE, GAME_COLOR_NUM, TOTAL_TRIES, TRIES,
    input  IN_GAME, WON, LOST
  );

  modport slave (
    input  BEGIN_GAME, final_SIZE, final_COLOR_NUM,
    input  MOVE_VALID, MOVE_COLOR, CORNER_COLOR,
    input  FLOOD_DONE, BOARD_FLOODED,
    output ACK_BEGIN_GAME, FLOOD_START, FLOOD_COLOR,
    output GAME_SIZE, GAME_COLOR_NUM, TOTAL_TRIES, TRIES,
    output IN_GAME, WON, LOST
  );
endinterface

// File: rtl/game_session.sv
// game_session
//   Game-side responder for the menu's start-game request. Acknowledges
//   BEGIN_GAME with a four-phase handshake, latches (clamped) board size and
//   color count, derives the try budget, then tracks moves between the
//   player and the flood-fill engine until a win or lose verdict.
//
//   Ports:
//     MASTER_CLOCK : system clock, all state on rising edge
//     RESET        : asynchronous, active-high
//     bus          : game_session_if.slave (menu / player / engine signals)
//
//   Optional feature macro: GAME_SESSION_TRY_LIMIT_EN
//     defined   -> try budget loaded into TOTAL_TRIES, LOST reachable
//     undefined -> TOTAL_TRIES held at 0, LOST never asserted
module game_session #(
  parameter logic [7:0] MAX_TRIES = 8'd255
) (
  input logic          MASTER_CLOCK,
  input logic          RESET,
  game_session_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACK,
    ST_PLAY,
    ST_WAIT_FLOOD,
    ST_WON,
    ST_LOST
  } state_t;

`ifdef GAME_SESSION_TRY_LIMIT_EN
  localparam logic [7:0] TOTAL_RESET = 8'd25;
`else
  localparam logic [7:0] TOTAL_RESET = 8'd0;
`endif

  state_t     r_state;
  state_t     w_next;
  logic       w_accept;
  logic       w_enterAck;
  logic       w_sizeValid;
  logic       w_colorValid;
  logic [4:0] w_size;
  logic [3:0] w_colors;
  logic [7:0] w_totalTries;

  logic       r_ack;
  logic       r_floodStart;
  logic [2:0] r_floodColor;
  logic [4:0] r_gameSize;
  logic [3:0] r_gameColorNum;
  logic [7:0] r_totalTries;
  logic [7:0] r_tries;
  logic       r_inGame;
  logic       r_won;
  logic       r_lost;

  // Anything outside the legal size/color sets falls back to the 14x14, 6-color game.
  always_comb begin
    w_sizeValid = 1'b0;
    case (bus.final_SIZE)
      5'd2, 5'd6, 5'd10, 5'd14, 5'd18, 5'd22, 5'd26: w_sizeValid = 1'b1;
      default: w_sizeValid = 1'b0;
    endcase
  end

  assign w_colorValid = (bus.final_COLOR_NUM >= 4'd3) && (bus.final_COLOR_NUM <= 4'd8);
  assign w_size       = w_sizeValid  ? bus.final_SIZE      : 5'd14;
  assign w_colors     = w_colorValid ? bus.final_COLOR_NUM : 4'd6;

`ifdef GAME_SESSION_TRY_LIMIT_EN
  logic [47:0] w_budgetRow;
  logic [2:0]  w_colorIdx;

  // Each row packs the budgets for 3..8 colors, 3 colors in the low byte.
  always_comb begin
    w_budgetRow = {8'd25, 8'd25, 8'd25, 8'd25, 8'd25, 8'd25};
    case (w_size)
      5'd2:    w_budgetRow = {8'd4,  8'd4,  8'd3,  8'd2,  8'd2,  8'd1};
      5'd6:    w_budgetRow = {8'd14, 8'd12, 8'd10, 8'd8,  8'd7,  8'd5};
      5'd10:   w_budgetRow = {8'd23, 8'd20, 8'd17, 8'd14, 8'd11, 8'd8};
      5'd14:   w_budgetRow = {8'd33, 8'd29, 8'd25, 8'd20, 8'd16, 8'd12};
      5'd18:   w_budgetRow = {8'd42, 8'd37, 8'd32, 8'd26, 8'd21, 8'd16};
      5'd22:   w_budgetRow = {8'd52, 8'd45, 8'd39, 8'd32, 8'd26, 8'd19};
      5'd26:   w_budgetRow = {8'd61, 8'd54, 8'd46, 8'd38, 8'd30, 8'd23};
      default: w_budgetRow = {8'd33, 8'd29, 8'd25, 8'd20, 8'd16, 8'd12};
    endcase
  end

  // 3..8 colors map to 0..5; the 3-bit subtraction wraps 8 onto 5 correctly.
  assign w_colorIdx   = w_colors[2:0] - 3'd3;
  assign w_totalTries = w_budgetRow[{w_colorIdx, 3'b000} +: 8];
`else
  assign w_totalTries = 8'd0;
`endif

  // Next-state logic; also decides whether a pick in PLAY is a legal move.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      ST_IDLE, ST_WON, ST_LOST: begin
        if (bus.BEGIN_GAME) w_next = ST_ACK;
      end
      ST_PLAY: begin
        if (bus.BEGIN_GAME) begin
          w_next = ST_ACK;
        end else if (bus.MOVE_VALID &&
                     ({1'b0, bus.MOVE_COLOR} < r_gameColorNum) &&
                     (bus.MOVE_COLOR != bus.CORNER_COLOR)) begin
          w_next   = ST_WAIT_FLOOD;
          w_accept = 1'b1;
        end
      end
      ST_ACK: begin
        if (!bus.BEGIN_GAME) w_next = ST_PLAY;
      end
      ST_WAIT_FLOOD: begin
        // A restart request is held off until the engine finishes the flood.
        if (bus.FLOOD_DONE) begin
          if (bus.BOARD_FLOODED) begin
            w_next = ST_WON;
`ifdef GAME_SESSION_TRY_LIMIT_EN
          end else if (r_tries >= r_totalTries) begin
            w_next = ST_LOST;
`endif
          end else begin
            w_next = ST_PLAY;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_enterAck = (w_next == ST_ACK) && (r_state != ST_ACK);

  // State register.
  always_ff @(posedge MASTER_CLOCK or posedge RESET) begin
    if (RESET) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Registered outputs follow the state being entered, so they line up with it.
  always_ff @(posedge MASTER_CLOCK or posedge RESET) begin
    if (RESET) begin
      r_ack          <= 1'b0;
      r_floodStart   <= 1'b0;
      r_floodColor   <= 3'd0;
      r_gameSize     <= 5'd14;
      r_gameColorNum <= 4'd6;
      r_totalTries   <= TOTAL_RESET;
      r_tries        <= 8'd0;
      r_inGame       <= 1'b0;
      r_won          <= 1'b0;
      r_lost         <= 1'b0;
    end else begin
      r_ack        <= (w_next == ST_ACK);
      r_inGame     <= (w_next == ST_PLAY) || (w_next == ST_WAIT_FLOOD);
      r_won        <= (w_next == ST_WON);
      r_lost       <= (w_next == ST_LOST);
      r_floodStart <= w_accept;
      if (w_enterAck) begin
        r_gameSize     <= w_size;
        r_gameColorNum <= w_colors;
        r_totalTries   <= w_totalTries;
        r_tries        <= 8'd0;
      end
      if (w_accept) begin
        r_floodColor <= bus.MOVE_COLOR;
        if (r_tries != MAX_TRIES) r_tries <= r_tries + 8'd1;
      end
    end
  end

  assign bus.ACK_BEGIN_GAME = r_ack;
  assign bus.FLOOD_START    = r_floodStart;
  assign bus.FLOOD_COLOR    = r_floodColor;
  assign bus.GAME_SIZE      = r_gameSize;
  assign bus.GAME_COLOR_NUM = r_gameColorNum;
  assign bus.TOTAL_TRIES    = r_totalTries;
  assign bus.TRIES          = r_tries;
  assign bus.IN_GAME        = r_inGame;
  assign bus.WON            = r_won;
  assign bus.LOST           = r_lost;

endmodule

// File: tb/tb_game_session.sv
// tb_game_session
//   Directed bench for game_session: handshake, move acceptance/rejection,
//   win/lose verdicts, input clamping and asynchronous reset mid-flood.
//   Expected values track GAME_SESSION_TRY_LIMIT_EN when it is defined.
module tb_game_session;

`ifdef GAME_SESSION_TRY_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  game_session_if bus ();

  game_session #(.MAX_TRIES(8'd255)) dut (
    .MASTER_CLOCK(clk),
    .RESET       (rst),
    .bus         (bus.slave)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".ack"},    8'(bus.ACK_BEGIN_GAME), 8'd0);
    checkOutput({tag, ".fstart"}, 8'(bus.FLOOD_START),    8'd0);
    checkOutput({tag, ".fcolor"}, 8'(bus.FLOOD_COLOR),    8'd0);
    checkOutput({tag, ".size"},   8'(bus.GAME_SIZE),      8'd14);
    checkOutput({tag, ".colors"}, 8'(bus.GAME_COLOR_NUM), 8'd6);
    checkOutput({tag, ".total"},  bus.TOTAL_TRIES,        LIM ? 8'd25 : 8'd0);
    checkOutput({tag, ".tries"},  bus.TRIES,              8'd0);
    checkOutput({tag, ".ingame"}, 8'(bus.IN_GAME),        8'd0);
    checkOutput({tag, ".won"},    8'(bus.WON),            8'd0);
    checkOutput({tag, ".lost"},   8'(bus.LOST),           8'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst                 = 1'b1;
    bus.BEGIN_GAME      = 1'b0;
    bus.final_SIZE      = 5'd0;
    bus.final_COLOR_NUM = 4'd0;
    bus.MOVE_VALID      = 1'b0;
    bus.MOVE_COLOR      = 3'd0;
    bus.CORNER_COLOR    = 3'd0;
    bus.FLOOD_DONE      = 1'b0;
    bus.BOARD_FLOODED   = 1'b0;

    // Reset state.
    #3;
    checkResetValues("reset");
    applyStimulus();
    rst = 1'b0;

    // Handshake: 10x10, 4 colors, request held for five edges.
    bus.final_SIZE      = 5'd10;
    bus.final_COLOR_NUM = 4'd4;
    bus.BEGIN_GAME      = 1'b1;
    applyStimulus();
    checkOutput("hs.ack1",   8'(bus.ACK_BEGIN_GAME), 8'd1);
    checkOutput("hs.size",   8'(bus.GAME_SIZE),      8'd10);
    checkOutput("hs.colors", 8'(bus.GAME_COLOR_NUM), 8'd4);
    checkOutput("hs.total",  bus.TOTAL_TRIES,        LIM ? 8'd11 : 8'd0);
    checkOutput("hs.ingame", 8'(bus.IN_GAME),        8'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      checkOutput("hs.ackHeld", 8'(bus.ACK_BEGIN_GAME), 8'd1);
    end
    bus.BEGIN_GAME = 1'b0;
    applyStimulus();
    checkOutput("hs.ackDrop", 8'(bus.ACK_BEGIN_GAME), 8'd0);
    checkOutput("hs.inGame",  8'(bus.IN_GAME),        8'd1);

    // Legal move: corner 0, pick 2.
    bus.CORNER_COLOR = 3'd0;
    bus.MOVE_COLOR   = 3'd2;
    bus.MOVE_VALID   = 1'b1;
    applyStimulus();
    checkOutput("mv.fstart", 8'(bus.FLOOD_START), 8'd1);
    checkOutput("mv.fcolor", 8'(bus.FLOOD_COLOR), 8'd2);
    checkOutput("mv.tries",  bus.TRIES,           8'd1);
    // A pick during the flood is ignored.
    bus.MOVE_COLOR = 3'd3;
    applyStimulus();
    checkOutput("mv.pulseEnd",  8'(bus.FLOOD_START), 8'd0);
    checkOutput("mv.colorHold", 8'(bus.FLOOD_COLOR), 8'd2);
    checkOutput("mv.waitIgn",   bus.TRIES,           8'd1);
    bus.MOVE_VALID    = 1'b0;
    bus.FLOOD_DONE    = 1'b1;
    bus.BOARD_FLOODED = 1'b0;
    applyStimulus();
    bus.FLOOD_DONE = 1'b0;
    checkOutput("mv.backPlay", 8'(bus.IN_GAME), 8'd1);
    checkOutput("mv.noWon",    8'(bus.WON),     8'd0);
    checkOutput("mv.noLost",   8'(bus.LOST),    8'd0);

    // Rejected picks: out of range (5 and boundary 4) and equal to corner.
    bus.CORNER_COLOR = 3'd1;
    bus.MOVE_VALID   = 1'b1;
    bus.MOVE_COLOR   = 3'd5;
    applyStimulus();
    checkOutput("rej.range5", 8'(bus.FLOOD_START), 8'd0);
    bus.MOVE_COLOR = 3'd4;
    applyStimulus();
    checkOutput("rej.range4", 8'(bus.FLOOD_START), 8'd0);
    bus.MOVE_COLOR = 3'd1;
    applyStimulus();
    checkOutput("rej.corner", 8'(bus.FLOOD_START), 8'd0);
    checkOutput("rej.tries",  bus.TRIES,           8'd1);
    // Highest legal color is accepted.
    bus.MOVE_COLOR = 3'd3;
    applyStimulus();
    bus.MOVE_VALID = 1'b0;
    checkOutput("acc.fstart", 8'(bus.FLOOD_START), 8'd1);
    checkOutput("acc.fcolor", 8'(bus.FLOOD_COLOR), 8'd3);
    checkOutput("acc.tries",  bus.TRIES,           8'd2);

    // Restart request during the flood is deferred until FLOOD_DONE.
    bus.final_SIZE      = 5'd2;
    bus.final_COLOR_NUM = 4'd3;
    bus.BEGIN_GAME      = 1'b1;
    applyStimulus();
    checkOutput("defer.ack",  8'(bus.ACK_BEGIN_GAME), 8'd0);
    checkOutput("defer.size", 8'(bus.GAME_SIZE),      8'd10);
    bus.FLOOD_DONE = 1'b1;
    applyStimulus();
    bus.FLOOD_DONE = 1'b0;
    checkOutput("defer.ack2", 8'(bus.ACK_BEGIN_GAME), 8'd0);
    checkOutput("defer.play", 8'(bus.IN_GAME),        8'd1);
    applyStimulus();
    checkOutput("abandon.ack",    8'(bus.ACK_BEGIN_GAME), 8'd1);
    checkOutput("abandon.size",   8'(bus.GAME_SIZE),      8'd2);
    checkOutput("abandon.colors", 8'(bus.GAME_COLOR_NUM), 8'd3);
    checkOutput("abandon.total",  bus.TOTAL_TRIES,        LIM ? 8'd1 : 8'd0);
    checkOutput("abandon.tries",  bus.TRIES,              8'd0);
    checkOutput("abandon.ingame", 8'(bus.IN_GAME),        8'd0);
    bus.BEGIN_GAME = 1'b0;
    applyStimulus();

    // Budget of one: a non-winning flood loses (when the limit is built in).
    bus.CORNER_COLOR = 3'd0;
    bus.MOVE_COLOR   = 3'd1;
    bus.MOVE_VALID   = 1'b1;
    applyStimulus();
    bus.MOVE_VALID = 1'b0;
    checkOutput("lose.tries", bus.TRIES, 8'd1);
    bus.FLOOD_DONE    = 1'b1;
    bus.BOARD_FLOODED = 1'b0;
    applyStimulus();
    bus.FLOOD_DONE = 1'b0;
    checkOutput("lose.lost",   8'(bus.LOST),    LIM ? 8'd1 : 8'd0);
    checkOutput("lose.won",    8'(bus.WON),     8'd0);
    checkOutput("lose.ingame", 8'(bus.IN_GAME), LIM ? 8'd0 : 8'd1);

    // Restart, then win on the last try: win beats budget exhaustion.
    bus.BEGIN_GAME = 1'b1;
    applyStimulus();
    checkOutput("rst2.ack",  8'(bus.ACK_BEGIN_GAME), 8'd1);
    checkOutput("rst2.lost", 8'(bus.LOST),           8'd0);
    bus.BEGIN_GAME = 1'b0;
    applyStimulus();
    bus.MOVE_COLOR = 3'd2;
    bus.MOVE_VALID = 1'b1;
    applyStimulus();
    bus.MOVE_VALID = 1'b0;
    bus.FLOOD_DONE    = 1'b1;
    bus.BOARD_FLOODED = 1'b1;
    applyStimulus();
    bus.FLOOD_DONE    = 1'b0;
    bus.BOARD_FLOODED = 1'b0;
    checkOutput("win.won",    8'(bus.WON),     8'd1);
    checkOutput("win.lost",   8'(bus.LOST),    8'd0);
    checkOutput("win.ingame", 8'(bus.IN_GAME), 8'd0);
    // Verdict holds; picks and stray FLOOD_DONE are ignored.
    bus.MOVE_COLOR = 3'd1;
    bus.MOVE_VALID = 1'b1;
    bus.FLOOD_DONE = 1'b1;
    applyStimulus();
    bus.MOVE_VALID = 1'b0;
    bus.FLOOD_DONE = 1'b0;
    checkOutput("won.hold",   8'(bus.WON),         8'd1);
    checkOutput("won.fstart", 8'(bus.FLOOD_START), 8'd0);
    checkOutput("won.tries",  bus.TRIES,           8'd1);

    // Clamp illegal size/colors.
    bus.final_SIZE      = 5'd13;
    bus.final_COLOR_NUM = 4'd9;
    bus.BEGIN_GAME      = 1'b1;
    applyStimulus();
    checkOutput("clamp.size",   8'(bus.GAME_SIZE),      8'd14);
    checkOutput("clamp.colors", 8'(bus.GAME_COLOR_NUM), 8'd6);
    checkOutput("clamp.total",  bus.TOTAL_TRIES,        LIM ? 8'd25 : 8'd0);
    checkOutput("clamp.won",    8'(bus.WON),            8'd0);
    bus.BEGIN_GAME = 1'b0;
    applyStimulus();

    // Largest table corner: 26x26, 8 colors, requested from PLAY.
    bus.final_SIZE      = 5'd26;
    bus.final_COLOR_NUM = 4'd8;
    bus.BEGIN_GAME      = 1'b1;
    applyStimulus();
    checkOutput("max.total",  bus.TOTAL_TRIES,        LIM ? 8'd61 : 8'd0);
    checkOutput("max.colors", 8'(bus.GAME_COLOR_NUM), 8'd8);
    bus.BEGIN_GAME = 1'b0;
    applyStimulus();

    // Asynchronous reset while waiting on the flood engine.
    bus.CORNER_COLOR = 3'd0;
    bus.MOVE_COLOR   = 3'd5;
    bus.MOVE_VALID   = 1'b1;
    applyStimulus();
    bus.MOVE_VALID = 1'b0;
    checkOutput("pre.fstart", 8'(bus.FLOOD_START), 8'd1);
    #2;
    rst = 1'b1;
    #1;
    checkResetValues("asyncRst");
    #1;
    rst = 1'b0;
    bus.FLOOD_DONE    = 1'b1;
    bus.BOARD_FLOODED = 1'b1;
    applyStimulus();
    bus.FLOOD_DONE    = 1'b0;
    bus.BOARD_FLOODED = 1'b0;
    checkOutput("postRst.won",    8'(bus.WON),            8'd0);
    checkOutput("postRst.ingame", 8'(bus.IN_GAME),        8'd0);
    checkOutput("postRst.ack",    8'(bus.ACK_BEGIN_GAME), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
